// File: rtl/pos_stack_drain.sv
// -----------------------------------------------------------------------------
// pos_stack_drain
//
// LIFO buffer on the output side of the Viterbi backtrace. During backtrace the
// controller pushes POS tags from the last word to the first. A push_done pulse
// then turns the stack around, and the block drains it through a valid/ready
// handshake. Tags therefore leave in sentence order, first word first. This
// block is the reader end of the Stack_POS write interface.
//
// Parameters:
//   size_state : width of one POS tag
//   DEPTH      : maximum tags per sentence (power of two, >= 2)
//   PTR_W      : stack pointer width, clog2(DEPTH)+1
//
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous, active-high reset
//   clear       : synchronous stack clear (reset_Stack_POS)
//   push        : write one tag (RW_Stack_POS)
//   push_tag    : tag to store
//   push_done   : one-cycle pulse, backtrace finished, start draining
//   stack_empty : registered tag count is 0
//   stack_full  : registered tag count equals DEPTH
//   busy        : high while filling or draining
//   out_valid   : out_tag is valid
//   out_ready   : consumer accepts out_tag
//   out_tag     : tag at the top of the stack (0 when out_valid is low)
//   out_last    : high with the final tag of the sentence
//   error       : sticky, set by overflow or by a push while draining
//   tag_count   : registered tag count (only with POS_STACK_COUNT_EN defined)
//
// Optional build macro: POS_STACK_COUNT_EN adds the tag_count output.
// -----------------------------------------------------------------------------
module pos_stack_drain #(
  parameter int unsigned size_state = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [size_state-1:0] push_tag,
  input  logic                  push_done,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [size_state-1:0] out_tag,
  output logic                  out_last,
  output logic                  error
`ifdef POS_STACK_COUNT_EN
  ,
  output logic [PTR_W-1:0]      tag_count
`endif
);

  localparam int unsigned      IDX_W   = PTR_W - 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        sp_q, sp_d;
  logic                    error_q, error_d;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic [IDX_W-1:0]        rd_idx;
  logic [size_state-1:0]   mem_q [DEPTH];

  // sp points at the next free slot; the top of stack lives at sp-1.
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - ONE_P);

  // ---------------------------------------------------------------------------
  // State / pointer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      error_q <= error_d;
    end
  end

  // Tag storage needs no reset: a slot is only read after it was written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: clear > push_done > push > pop.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    error_d = error_q;
    wr_en   = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
      sp_d    = '0;
      error_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // push_done on an empty stack is an empty sentence: nothing to drain.
          if (!push_done && push) begin
            wr_en   = 1'b1;
            sp_d    = sp_q + ONE_P;
            state_d = S_FILL;
          end
        end

        S_FILL: begin
          if (push_done) begin
            state_d = S_DRAIN;
          end else if (push) begin
            if (sp_q == DEPTH_P) begin
              error_d = 1'b1;
            end else begin
              wr_en = 1'b1;
              sp_d  = sp_q + ONE_P;
            end
          end
        end

        S_DRAIN: begin
          // Writes are not allowed while the stack is turned around.
          if (push) begin
            error_d = 1'b1;
          end
          if (out_ready) begin
            sp_d = sp_q - ONE_P;
            if (sp_q == ONE_P) begin
              state_d = S_IDLE;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all decoded from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid   = (state_q == S_DRAIN);
    out_tag     = '0;
    out_last    = 1'b0;
    if (out_valid) begin
      out_tag  = mem_q[rd_idx];
      out_last = (sp_q == ONE_P);
    end
    stack_empty = (sp_q == '0);
    stack_full  = (sp_q == DEPTH_P);
    busy        = (state_q != S_IDLE);
    error       = error_q;
  end

`ifdef POS_STACK_COUNT_EN
  assign tag_count = sp_q;
`endif

endmodule

// File: tb/tb_pos_stack_drain.sv
module tb_pos_stack_drain;

  localparam int unsigned SS    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 5;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          clear     = 1'b0;
  logic          push      = 1'b0;
  logic [SS-1:0] push_tag  = '0;
  logic          push_done = 1'b0;
  logic          out_ready = 1'b0;
  logic          stack_empty, stack_full, busy, out_valid, out_last, error;
  logic [SS-1:0] out_tag;
`ifdef POS_STACK_COUNT_EN
  logic [PTR_W-1:0] tag_count;
`endif

  pos_stack_drain #(
    .size_state(SS),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .push       (push),
    .push_tag   (push_tag),
    .push_done  (push_done),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_last   (out_last),
    .error      (error)
`ifdef POS_STACK_COUNT_EN
    ,
    .tag_count  (tag_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a queue of stored tags plus "turned around" and error
  // ---------------------------------------------------------------------------
  int mq[$];
  bit m_drain = 1'b0;
  bit m_err   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_drain = 1'b0;
      m_err   = 1'b0;
    end else if (clear) begin
      mq.delete();
      m_drain = 1'b0;
      m_err   = 1'b0;
    end else if (m_drain) begin
      if (push) m_err = 1'b1;
      if (out_ready) begin
        void'(mq.pop_back());
        if (mq.size() == 0) m_drain = 1'b0;
      end
    end else if (push_done) begin
      if (mq.size() > 0) m_drain = 1'b1;
    end else if (push) begin
      if (mq.size() < DEPTH) mq.push_back(int'(push_tag));
      else m_err = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model, plus capture of accepted tags
  // ---------------------------------------------------------------------------
  int cap_tag[$];
  int cap_last[$];
  int exp_tag;

  always @(negedge clk) begin
    exp_tag = (m_drain && mq.size() > 0) ? mq[mq.size()-1] : 0;
    check("m_empty", stack_empty, mq.size() == 0);
    check("m_full", stack_full, mq.size() == DEPTH);
    check("m_busy", busy, mq.size() > 0);
    check("m_valid", out_valid, m_drain);
    check("m_tag", out_tag, exp_tag);
    check("m_last", out_last, m_drain && mq.size() == 1);
    check("m_error", error, m_err);
`ifdef POS_STACK_COUNT_EN
    check("m_count", tag_count, mq.size());
`endif
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      cap_tag.push_back(int'(out_tag));
      cap_last.push_back(int'(out_last));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after the rising edge
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_push(input int tag);
    push     = 1'b1;
    push_tag = SS'(tag);
    tick();
    push     = 1'b0;
  endtask

  task automatic start_drain(input logic rdy);
    push_done = 1'b1;
    out_ready = rdy;
    tick();
    push_done = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && out_valid === 1'b1; i++) tick();
    check("drain_timeout", out_valid, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  int exp_basic[4] = '{9, 1, 7, 3};
  int exp_last[4]  = '{0, 0, 0, 1};

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_empty", stack_empty, 1);
    check("rst_full", stack_full, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_tag", out_tag, 0);
    check("rst_last", out_last, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    tick();

    // Basic order
    cap_tag.delete(); cap_last.delete();
    do_push(3); do_push(7); do_push(1); do_push(9);
    check("basic_sp4_empty", stack_empty, 0);
    start_drain(1'b1);
    check("basic_lat_valid", out_valid, 1);
    check("basic_first_tag", out_tag, 9);
    wait_idle();
    check("basic_count", cap_tag.size(), 4);
    for (int i = 0; i < 4 && i < cap_tag.size(); i++) begin
      check("basic_tag", cap_tag[i], exp_basic[i]);
      check("basic_last", cap_last[i], exp_last[i]);
    end
    check("basic_end_empty", stack_empty, 1);
    check("basic_end_busy", busy, 0);

    // Backpressure
    cap_tag.delete(); cap_last.delete();
    do_push(5); do_push(2);
    start_drain(1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_hold_tag", out_tag, 2);
      check("bp_hold_last", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    check("bp_count", cap_tag.size(), 2);
    if (cap_tag.size() == 2) begin
      check("bp_tag0", cap_tag[0], 2);
      check("bp_tag1", cap_tag[1], 5);
      check("bp_last0", cap_last[0], 0);
      check("bp_last1", cap_last[1], 1);
    end

    // Overflow
    cap_tag.delete(); cap_last.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      do_push(i % 16);
      if (i == 15) begin
        check("ovf_full16", stack_full, 1);
        check("ovf_err16", error, 0);
      end
    end
    check("ovf_full17", stack_full, 1);
    check("ovf_err17", error, 1);
    start_drain(1'b1);
    wait_idle();
    check("ovf_count", cap_tag.size(), 16);
    if (cap_tag.size() == 16) begin
      check("ovf_first", cap_tag[0], 15);
      check("ovf_lastval", cap_tag[15], 0);
      check("ovf_lastflag", cap_last[15], 1);
    end
    check("ovf_sticky", error, 1);
    do_clear();
    check("ovf_clr_err", error, 0);

    // Illegal push during drain
    cap_tag.delete(); cap_last.delete();
    out_ready = 1'b0;
    do_push(4); do_push(6);
    start_drain(1'b0);
    do_push(8);
    check("ill_err", error, 1);
    check("ill_tag", out_tag, 6);
    check("ill_empty", stack_empty, 0);
    tick();
    check("ill_hold", out_tag, 6);
    out_ready = 1'b1;
    wait_idle();
    check("ill_count", cap_tag.size(), 2);
    if (cap_tag.size() == 2) begin
      check("ill_tag0", cap_tag[0], 6);
      check("ill_tag1", cap_tag[1], 4);
    end
    do_clear();

    // Empty sentence
    start_drain(1'b1);
    check("empty_valid", out_valid, 0);
    check("empty_busy", busy, 0);
    tick();
    check("empty_valid2", out_valid, 0);

    // Clear mid-drain with 3 tags left
    out_ready = 1'b0;
    do_push(1); do_push(2); do_push(3); do_push(4); do_push(5);
    start_drain(1'b0);
    do_push(11);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    check("clr_pre_tag", out_tag, 3);
    check("clr_pre_err", error, 1);
    do_clear();
    check("clr_valid", out_valid, 0);
    check("clr_empty", stack_empty, 1);
    check("clr_error", error, 0);
    check("clr_busy", busy, 0);

    // Asynchronous reset between clock edges
    do_push(7); do_push(8);
    start_drain(1'b0);
    do_push(12);
    check("ar_pre_valid", out_valid, 1);
    check("ar_pre_err", error, 1);
    #1;
    reset = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_empty", stack_empty, 1);
    check("ar_full", stack_full, 0);
    check("ar_busy", busy, 0);
    check("ar_error", error, 0);
    check("ar_tag", out_tag, 0);
    check("ar_last", out_last, 0);
`ifdef POS_STACK_COUNT_EN
    check("ar_count", tag_count, 0);
`endif
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pos_stack_drain.md
Name: pos_stack_drain

Overview:
- LIFO buffer on the output side of the Viterbi backtrace.
- The controller pushes POS tags during backtrace, from the last word to the first.
- This block stores them, reports stack_empty back to the controller, and then drains them with a valid/ready handshake, so tags come out in sentence order (first word first).
- It is the reader end of the Stack_POS write interface.

Parameters:
- size_state, 4, width of a POS tag (matches the controller's state/tag width)
- DEPTH, 16, maximum tags per sentence; power of two, at least 2
- PTR_W, 5, stack pointer width; must equal clog2(DEPTH)+1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous stack clear (driven by reset_Stack_POS)
- push  input  1  write one tag (driven by RW_Stack_POS)
- push_tag  input  size_state  tag to store
- push_done  input  1  one-cycle pulse: backtrace finished, start draining
- stack_empty  output  1  high when the stored tag count is 0
- stack_full  output  1  high when the stored tag count equals DEPTH
- busy  output  1  high in FILL or DRAIN
- out_valid  output  1  out_tag is valid
- out_ready  input  1  consumer accepts out_tag
- out_tag  output  size_state  tag at the top of the stack
- out_last  output  1  high with the final tag of the sentence
- error  output  1  sticky; set by overflow, or by a push during DRAIN

Behaviour:
- Reset (asynchronous, active-high), all outputs:
  - sp=0, state=IDLE
  - stack_empty=1, stack_full=0, busy=0
  - out_valid=0, out_tag=0, out_last=0, error=0
  - Memory contents are don't-care.
- Priority each cycle: reset > clear > push_done > push > pop.
- clear:
  - Next cycle: sp=0, state=IDLE, error=0.
  - A push or push_done in the same cycle is ignored.
- States are IDLE, FILL, DRAIN.
- IDLE:
  - push -> mem[sp]=push_tag, sp+1, go to FILL.
  - push_done with sp=0 -> stay in IDLE; no output is produced.
- FILL:
  - push with sp<DEPTH -> store the tag, sp+1.
  - push with sp=DEPTH -> tag dropped, error=1, sp unchanged.
  - push_done -> go to DRAIN next cycle. A push in the same cycle is ignored and does not set error.
- DRAIN:
  - out_valid=1 in every DRAIN cycle.
  - out_tag=mem[sp-1]; out_last=(sp==1).
  - out_valid & out_ready -> sp-1.
  - The pop that consumes the last tag -> IDLE next cycle, out_valid=0.
  - out_ready low -> out_tag and out_last hold stable.
  - push in DRAIN -> ignored, error=1.
  - push_done in DRAIN -> ignored.
- Latency:
  - A push in cycle N is reflected in sp, stack_empty and stack_full in cycle N+1.
  - push_done in cycle N gives out_valid=1 in cycle N+1.
  - Throughput is one tag per cycle while out_ready=1.
- Flags and outputs outside DRAIN:
  - stack_empty and stack_full are decoded from registered sp (glitch-free).
  - out_tag=0 and out_last=0 whenever out_valid=0.
- sp never wraps: it saturates at DEPTH and never goes below 0.
- error stays set until reset or clear.

Optional Feature:
- Macro: POS_STACK_COUNT_EN.
- Defined: adds output tag_count [PTR_W-1:0] equal to registered sp. It resets to 0 and follows the same update timing as stack_empty.
- Undefined: no tag_count port; all other behaviour is identical.

Test Plan:
- Basic order: push tags 3,7,1,9 on consecutive cycles, then push_done, out_ready=1 -> out_tag sequence 9,1,7,3 on 4 consecutive cycles; out_last only with 3; stack_empty=1 and state IDLE afterwards.
- Backpressure: 2 tags (5,2); out_ready low for 3 cycles after DRAIN entry -> out_tag holds 2 with out_valid=1; raise out_ready -> 2 then 5 with out_last=1.
- Overflow: 17 pushes with DEPTH=16 -> stack_full=1 after the 16th; 17th dropped; error=1; drain yields exactly 16 tags.
- Illegal push: push during DRAIN -> error=1; sp decrements only on handshake.
- Empty sentence: push_done with no prior push -> out_valid stays 0, state IDLE.
- Clear and reset: clear mid-DRAIN with 3 tags left -> next cycle out_valid=0, stack_empty=1, error=0. Async reset asserted between clock edges -> outputs reach reset values immediately, without waiting for a clock edge.
